xor_fold_stream: RTL and testbench

//  Multi-channel streaming XOR-fold compressor. Each channel's W_IN-bit word is folded
//  to W_OUT bits by XORing its W_IN/W_OUT slices. In FOLD mode every accepted beat

---
 rtl/xor_fold_stream.sv | 98 +++++++++
 tb/tb_xor_fold_stream.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_fold_stream.sv
// Multi-channel streaming XOR-fold compressor with valid/ready on both sides.
// FOLD mode emits one result per beat; ACCUM mode XOR-accumulates a whole burst into one result.
module xor_fold_stream #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 8,
  parameter int CH    = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*W_IN-1:0]    in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*W_OUT-1:0]   out_data,
  output logic [CNT_W-1:0]      out_beats
);

  localparam int N_SLICE = W_IN / W_OUT;

  generate
    if ((W_IN % W_OUT) != 0) begin : g_width_check
      $error("xor_fold_stream: W_IN must be an integer multiple of W_OUT");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE, ACC} state_t;

  state_t               state;
  logic [CH*W_OUT-1:0]  acc;
  logic [CNT_W-1:0]     cnt;
  logic [CH*W_OUT-1:0]  fold;
  logic [CNT_W-1:0]     cnt_sat;
  logic                 accept;

  always_comb begin
    fold = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < N_SLICE; k++) begin
        fold[c*W_OUT +: W_OUT] = fold[c*W_OUT +: W_OUT] ^ in_data[c*W_IN + k*W_OUT +: W_OUT];
      end
    end
  end

  // A new beat is taken whenever the output slot is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_sat  = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        case (state)
          IDLE: begin
            if (!mode || in_last) begin
              out_data  <= fold;
              out_beats <= CNT_W'(1);
              out_valid <= 1'b1;
            end else begin
              acc   <= fold;
              cnt   <= CNT_W'(1);
              state <= ACC;
            end
          end
          ACC: begin
            // mode is deliberately not consulted here so a burst always closes as ACCUM.
            if (!in_last) begin
              acc <= acc ^ fold;
              cnt <= cnt_sat;
            end else begin
              out_data  <= acc ^ fold;
              out_beats <= cnt_sat;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xor_fold_stream.sv
// Directed bench for xor_fold_stream: default build, a CNT_W=2 build and a W_IN=32/CH=3 build.
module tb_xor_fold_stream;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Default-parameter instance
  logic        a_mode, a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
  logic [31:0] a_in_data;
  logic [15:0] a_out_data;
  logic [7:0]  a_out_beats;

  xor_fold_stream dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_beats(a_out_beats)
  );

  // Narrow beat counter instance for saturation
  logic        b_mode, b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_beats;

  xor_fold_stream #(.W_IN(16), .W_OUT(8), .CH(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_beats(b_out_beats)
  );

  // Wide four-slice, three-channel instance
  logic        c_mode, c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready;
  logic [95:0] c_in_data;
  logic [23:0] c_out_data;
  logic [7:0]  c_out_beats;

  xor_fold_stream #(.W_IN(32), .W_OUT(8), .CH(3), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .mode(c_mode), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_beats(c_out_beats)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic v, input logic [31:0] d,
                               input logic l, input logic r);
    a_mode      = m;
    a_in_valid  = v;
    a_in_data   = d;
    a_in_last   = l;
    a_out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [15:0] b_beats [5];

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    c_mode = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_out_ready = 1'b1;
    #2;
    checkOutput("reset_out_valid", 96'(a_out_valid), 96'd0);
    checkOutput("reset_out_data",  96'(a_out_data),  96'd0);
    checkOutput("reset_out_beats", 96'(a_out_beats), 96'd0);
    checkOutput("reset_in_ready",  96'(a_in_ready),  96'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // FOLD single beat
    applyStimulus(1'b0, 1'b1, {16'h1234, 16'hA55A}, 1'b0, 1'b1);
    tick();
    checkOutput("fold_valid", 96'(a_out_valid), 96'd1);
    checkOutput("fold_data",  96'(a_out_data),  96'h26FF);
    checkOutput("fold_beats", 96'(a_out_beats), 96'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("fold_drained", 96'(a_out_valid), 96'd0);

    // ACCUM three-beat burst
    applyStimulus(1'b1, 1'b1, {16'h0000, 16'h0102}, 1'b0, 1'b1);
    tick();
    checkOutput("accum_b1_no_valid", 96'(a_out_valid), 96'd0);
    applyStimulus(1'b1, 1'b1, {16'h0000, 16'h0304}, 1'b0, 1'b1);
    tick();
    checkOutput("accum_b2_no_valid", 96'(a_out_valid), 96'd0);
    applyStimulus(1'b1, 1'b1, {16'h0000, 16'h0506}, 1'b1, 1'b1);
    tick();
    checkOutput("accum_valid", 96'(a_out_valid), 96'd1);
    checkOutput("accum_data",  96'(a_out_data),  96'h0007);
    checkOutput("accum_beats", 96'(a_out_beats), 96'd3);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // FOLD with output stalled for three cycles
    applyStimulus(1'b0, 1'b1, {16'h0F00, 16'h0001}, 1'b0, 1'b0);
    tick();
    checkOutput("stall_load_data", 96'(a_out_data), 96'h0F01);
    checkOutput("stall_in_ready",  96'(a_in_ready), 96'd0);
    applyStimulus(1'b0, 1'b1, {16'h00F0, 16'h0200}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold_data",  96'(a_out_data),  96'h0F01);
      checkOutput("stall_hold_valid", 96'(a_out_valid), 96'd1);
      checkOutput("stall_hold_ready", 96'(a_in_ready),  96'd0);
    end
    a_out_ready = 1'b1;
    #1;
    checkOutput("stall_release_ready", 96'(a_in_ready), 96'd1);
    tick();
    checkOutput("stream_beat2_data",  96'(a_out_data),  96'hF002);
    checkOutput("stream_beat2_valid", 96'(a_out_valid), 96'd1);
    applyStimulus(1'b0, 1'b1, {16'h3300, 16'h0004}, 1'b0, 1'b1);
    tick();
    checkOutput("stream_beat3_data", 96'(a_out_data), 96'h3304);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("stream_drained", 96'(a_out_valid), 96'd0);

    // Mode flips to FOLD during a four-beat ACCUM burst
    applyStimulus(1'b1, 1'b1, {16'h0100, 16'h0001}, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, {16'h0000, 16'h0002}, 1'b0, 1'b1);
    tick();
    checkOutput("flip_b2_no_valid", 96'(a_out_valid), 96'd0);
    applyStimulus(1'b0, 1'b1, {16'h0000, 16'h0004}, 1'b0, 1'b1);
    tick();
    checkOutput("flip_b3_no_valid", 96'(a_out_valid), 96'd0);
    applyStimulus(1'b0, 1'b1, {16'h0000, 16'h0008}, 1'b1, 1'b1);
    tick();
    checkOutput("flip_valid", 96'(a_out_valid), 96'd1);
    checkOutput("flip_data",  96'(a_out_data),  96'h010F);
    checkOutput("flip_beats", 96'(a_out_beats), 96'd4);
    applyStimulus(1'b0, 1'b1, {16'hAB00, 16'h00CD}, 1'b0, 1'b1);
    tick();
    checkOutput("after_flip_fold_data",  96'(a_out_data),  96'hABCD);
    checkOutput("after_flip_fold_beats", 96'(a_out_beats), 96'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Reset while A holds a pending output and B is mid-burst
    applyStimulus(1'b0, 1'b1, {16'h0011, 16'h2200}, 1'b0, 1'b0);
    b_mode = 1'b1; b_in_valid = 1'b1; b_in_data = {16'h0000, 16'hFF00}; b_in_last = 1'b0;
    tick();
    checkOutput("pre_reset_pending", 96'(a_out_valid), 96'd1);
    a_in_valid = 1'b0;
    tick();
    b_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_a_valid", 96'(a_out_valid), 96'd0);
    checkOutput("midreset_a_data",  96'(a_out_data),  96'd0);
    checkOutput("midreset_a_ready", 96'(a_in_ready),  96'd1);
    checkOutput("midreset_b_valid", 96'(b_out_valid), 96'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Five-beat burst on the two-bit counter: count saturates, data covers all beats
    b_beats[0] = 16'h0001; b_beats[1] = 16'h0002; b_beats[2] = 16'h0004;
    b_beats[3] = 16'h0008; b_beats[4] = 16'h0010;
    b_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = {16'h0000, b_beats[i]};
      b_in_last  = (i == 4);
      tick();
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    checkOutput("sat_valid", 96'(b_out_valid), 96'd1);
    checkOutput("sat_data",  96'(b_out_data),  96'h001F);
    checkOutput("sat_beats", 96'(b_out_beats), 96'd3);

    // Single-beat ACCUM burst starting from IDLE
    applyStimulus(1'b1, 1'b1, {16'h5500, 16'h00AA}, 1'b1, 1'b1);
    tick();
    checkOutput("accum_single_data",  96'(a_out_data),  96'h55AA);
    checkOutput("accum_single_beats", 96'(a_out_beats), 96'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Wide build: FOLD then a two-beat ACCUM burst
    c_mode = 1'b0; c_in_valid = 1'b1;
    c_in_data = {32'h12345678, 32'hFF00FF00, 32'h01020304};
    tick();
    checkOutput("wide_fold_data",  96'(c_out_data),  96'h080004);
    checkOutput("wide_fold_beats", 96'(c_out_beats), 96'd1);
    c_mode = 1'b1;
    tick();
    checkOutput("wide_accum_b1_no_valid", 96'(c_out_valid), 96'd0);
    c_in_data = {32'h00000000, 32'h80000000, 32'h00000001};
    c_in_last = 1'b1;
    tick();
    c_in_valid = 1'b0;
    c_in_last  = 1'b0;
    checkOutput("wide_accum_valid", 96'(c_out_valid), 96'd1);
    checkOutput("wide_accum_data",  96'(c_out_data),  96'h088005);
    checkOutput("wide_accum_beats", 96'(c_out_beats), 96'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
